id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the 5-stage RV32I core, directly downstream of the register file.
- Captures the register-file read data and the decoded fields of the ID-stage instruction, and presents them to EX one cycle later.
- Detects load-use hazards, inserts bubbles, honours flush from branch resolution, and bypasses same-cycle writeback data onto operands.
- Keeps saturating stall and flush performance counters.

Parameters:
- XLEN, 32, datapath width.
- CTRL_W, 16, width of the opaque decoded control bundle passed through to EX.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID holds a valid instruction.
- id_pc  in  XLEN  PC of ID instruction.
- id_rs1_add, id_rs2_add, id_rd_add  in  5 each  decoded register indices.
- id_use_rs1, id_use_rs2  in  1 each  instruction actually reads rs1/rs2.
- id_imm  in  XLEN  decoded immediate.
- id_ctrl  in  CTRL_W  decoded control bundle.
- rs1, rs2  in  XLEN each  register-file read data.
- wb_RegWEn  in  1  writeback write enable (same signal driven to register file).
- wb_rd_add  in  5  writeback destination.
- wb_dataW  in  XLEN  writeback data.
- ex_mem_read  in  1  instruction currently in EX is a load.
- flush  in  1  branch/jump taken in EX; kill ID instruction.
- hold_ex  in  1  downstream stall; freeze this register.
- stall_id  out  1  combinational: IF and ID must hold this cycle.
- ex_valid  out  1  EX slot valid.
- ex_pc, ex_imm, ex_rs1_data, ex_rs2_data  out  XLEN each  registered.
- ex_rs1_add, ex_rs2_add, ex_rd_add  out  5 each  registered.
- ex_ctrl  out  CTRL_W  registered.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Behaviour:
- Reset (rst_n low, asynchronous): every registered output is 0, including ex_valid, ex_ctrl and both counters. stall_id is 0 while in reset.
- Load-use hazard: lu = ex_valid & ex_mem_read & (ex_rd_add != 0) & id_valid & ((id_use_rs1 & id_rs1_add == ex_rd_add) | (id_use_rs2 & id_rs2_add == ex_rd_add)).
- stall_id = (lu | hold_ex) & ~flush. Combinational, zero latency.
- Operand bypass: op1 = wb_dataW if (wb_RegWEn & wb_rd_add != 0 & wb_rd_add == id_rs1_add), else rs1. op2 is identical with rs2. Index 0 is never bypassed; a read of x0 yields whatever rs1/rs2 delivers.
- Register update, priority highest first:
  1. flush: ex_valid <= 0, ex_ctrl <= 0, other fields don't-care (holding is acceptable). Applies even when hold_ex is high.
  2. hold_ex: all ex_* hold.
  3. lu: bubble; ex_valid <= 0, ex_ctrl <= 0.
  4. Otherwise: capture ex_valid <= id_valid, plus op1/op2, pc, imm, addresses and ctrl. When id_valid = 0, ex_ctrl <= 0.
- Latency: one cycle ID to EX. A load-use stall lasts exactly one cycle, because the load leaves EX on the bubble cycle.
- Counters: stall_cnt increments in each cycle where stall_id = 1. flush_cnt increments in each cycle where flush = 1 & (id_valid | ex_valid). Both saturate at all-ones and never wrap.
- Simultaneous flush and lu: flush wins, no stall, stall_cnt does not increment.
- Reset asserted mid-stall: immediate return to the reset state; no residual stall afterwards.

Test Plan:
- Reset then a plain ALU op (id_valid=1, pc=0x100, rs1=5, rs2=7, imm=0x10, rd=3) -> next cycle ex_valid=1, ex_pc=0x100, ex_rs1_data=5, ex_rs2_data=7, ex_rd_add=3, stall_id=0.
- EX holds a load with rd=6; ID reads rs2=6 with id_use_rs2=1 -> stall_id=1 for exactly 1 cycle, bubble (ex_valid=0, ex_ctrl=0), stall_cnt=1, then the instruction issues. Repeat with rd=0 -> no stall.
- wb_RegWEn=1, wb_rd_add=9, wb_dataW=0xDEADBEEF, id_rs1_add=9, rs1=0x1 -> ex_rs1_data=0xDEADBEEF. Same with wb_rd_add=0 -> ex_rs1_data=0x1.
- flush=1 together with lu=1 and hold_ex=1 -> ex_valid=0 next cycle, stall_id=0, flush_cnt+1, stall_cnt unchanged.
- hold_ex high for 3 cycles with changing ID inputs -> all ex_* constant, stall_id=1 each cycle, stall_cnt+3.
- Force stall_cnt to all-ones and stall once more -> stays all-ones. Assert rst_n=0 mid-stall -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage
//  Description : Decode-to-execute pipeline register of a 5-stage RV32I core.
//                Captures register-file read data and decoded ID fields and
//                presents them to EX one cycle later. Detects load-use
//                hazards (one-cycle bubble), honours branch flush and
//                downstream hold, bypasses same-cycle writeback data onto
//                the operands, and keeps saturating stall/flush counters.
//
//  Ports
//    clk, rst_n                 clock, asynchronous active-low reset
//    id_*                       ID-stage instruction and decoded fields
//    rs1, rs2                   register-file read data
//    wb_RegWEn/wb_rd_add/wb_dataW  writeback port (also feeds the regfile)
//    ex_mem_read                instruction in EX is a load
//    flush                      taken branch/jump in EX; kill ID instruction
//    hold_ex                    downstream stall; freeze this register
//    stall_id                   combinational: IF/ID must hold this cycle
//    ex_*                       registered EX-stage fields
//    stall_cnt, flush_cnt       saturating performance counters
//
//  Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    // ID stage
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [4:0]        id_rs1_add,
    input  logic [4:0]        id_rs2_add,
    input  logic [4:0]        id_rd_add,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_ctrl,

    // Register-file read data
    input  logic [XLEN-1:0]   rs1,
    input  logic [XLEN-1:0]   rs2,

    // Writeback
    input  logic              wb_RegWEn,
    input  logic [4:0]        wb_rd_add,
    input  logic [XLEN-1:0]   wb_dataW,

    // Hazard / control
    input  logic              ex_mem_read,
    input  logic              flush,
    input  logic              hold_ex,
    output logic              stall_id,

    // EX stage
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_imm,
    output logic [XLEN-1:0]   ex_rs1_data,
    output logic [XLEN-1:0]   ex_rs2_data,
    output logic [4:0]        ex_rs1_add,
    output logic [4:0]        ex_rs2_add,
    output logic [4:0]        ex_rd_add,
    output logic [CTRL_W-1:0] ex_ctrl,

    // Performance counters
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CTRL_W-1:0] c_CTRL_NOP = '0;
    localparam logic [4:0]        c_X0       = 5'd0;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_imm;
    logic [XLEN-1:0]   r_op1;
    logic [XLEN-1:0]   r_op2;
    logic [4:0]        r_rs1_add;
    logic [4:0]        r_rs2_add;
    logic [4:0]        r_rd_add;
    logic [CTRL_W-1:0] r_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;

    // ------------------------------------------------------------------
    // Combinational hazard detection
    // ------------------------------------------------------------------
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_lu;
    logic w_stall_id;
    logic w_flush_evt;

    // A load in EX with a real destination that the ID instruction reads.
    assign w_rs1_hit = id_use_rs1 && (id_rs1_add == r_rd_add);
    assign w_rs2_hit = id_use_rs2 && (id_rs2_add == r_rd_add);
    assign w_lu      = r_valid && ex_mem_read && (r_rd_add != c_X0) &&
                       id_valid && (w_rs1_hit || w_rs2_hit);

    // Flush kills the ID instruction, so any stall request is moot.
    // Gating with rst_n keeps stall_id low while reset is held even if
    // hold_ex is asserted by downstream logic.
    assign w_stall_id  = rst_n && (w_lu || hold_ex) && !flush;

    // Only count flushes that actually kill something.
    assign w_flush_evt = flush && (id_valid || r_valid);

    // ------------------------------------------------------------------
    // Writeback bypass: the register file is written on the same edge
    // this register captures, so its read data is stale for wb_rd_add.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;
    logic            w_byp1;
    logic            w_byp2;

    assign w_byp1 = wb_RegWEn && (wb_rd_add != c_X0) && (wb_rd_add == id_rs1_add);
    assign w_byp2 = wb_RegWEn && (wb_rd_add != c_X0) && (wb_rd_add == id_rs2_add);
    assign w_op1  = w_byp1 ? wb_dataW : rs1;
    assign w_op2  = w_byp2 ? wb_dataW : rs2;

    // ------------------------------------------------------------------
    // Pipeline register
    // Priority: flush > hold_ex > load-use bubble > capture.
    // On flush/bubble the data fields simply hold; only valid and ctrl
    // are forced so EX sees a clean NOP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_imm     <= '0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_rs1_add <= '0;
            r_rs2_add <= '0;
            r_rd_add  <= '0;
            r_ctrl    <= '0;
        end else if (flush) begin
            r_valid   <= 1'b0;
            r_ctrl    <= c_CTRL_NOP;
        end else if (hold_ex) begin
            r_valid   <= r_valid;
        end else if (w_lu) begin
            r_valid   <= 1'b0;
            r_ctrl    <= c_CTRL_NOP;
        end else begin
            r_valid   <= id_valid;
            r_pc      <= id_pc;
            r_imm     <= id_imm;
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_rs1_add <= id_rs1_add;
            r_rs2_add <= id_rs2_add;
            r_rd_add  <= id_rd_add;
            r_ctrl    <= id_valid ? id_ctrl : c_CTRL_NOP;
        end
    end

    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_id && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + c_CNT_ONE;
            end
            if (w_flush_evt && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign stall_id    = w_stall_id;
    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_imm      = r_imm;
    assign ex_rs1_data = r_op1;
    assign ex_rs2_data = r_op2;
    assign ex_rs1_add  = r_rs1_add;
    assign ex_rs2_add  = r_rs2_add;
    assign ex_rd_add   = r_rd_add;
    assign ex_ctrl     = r_ctrl;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage
//  Description : Self-checking bench for id_ex_stage. Directed scenarios
//                followed by randomized cycles, all compared against a
//                behavioural model of the EX-stage slot and counters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

    localparam int XLEN   = 32;
    localparam int CTRL_W = 16;
    localparam int CNT_W  = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk;
    logic              rst_n;
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [4:0]        id_rs1_add, id_rs2_add, id_rd_add;
    logic              id_use_rs1, id_use_rs2;
    logic [XLEN-1:0]   id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic [XLEN-1:0]   rs1, rs2;
    logic              wb_RegWEn;
    logic [4:0]        wb_rd_add;
    logic [XLEN-1:0]   wb_dataW;
    logic              ex_mem_read, flush, hold_ex;
    logic              stall_id;
    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]        ex_rs1_add, ex_rs2_add, ex_rd_add;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_add(id_rs1_add), .id_rs2_add(id_rs2_add), .id_rd_add(id_rd_add),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_imm(id_imm), .id_ctrl(id_ctrl),
        .rs1(rs1), .rs2(rs2),
        .wb_RegWEn(wb_RegWEn), .wb_rd_add(wb_rd_add), .wb_dataW(wb_dataW),
        .ex_mem_read(ex_mem_read), .flush(flush), .hold_ex(hold_ex),
        .stall_id(stall_id),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1_add(ex_rs1_add), .ex_rs2_add(ex_rs2_add), .ex_rd_add(ex_rd_add),
        .ex_ctrl(ex_ctrl), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model of the EX slot ----------------
    logic              m_valid;
    logic [XLEN-1:0]   m_pc, m_imm, m_op1, m_op2;
    logic [4:0]        m_rs1a, m_rs2a, m_rd;
    logic [CTRL_W-1:0] m_ctrl;
    int                m_scnt, m_fcnt;
    logic              last_stall;

    function automatic logic model_lu();
        bit reads_rd;
        reads_rd = (id_use_rs1 && id_rs1_add == m_rd) || (id_use_rs2 && id_rs2_add == m_rd);
        return m_valid && ex_mem_read && (m_rd != 0) && id_valid && reads_rd;
    endfunction

    function automatic logic [XLEN-1:0] fwd(input logic [4:0] a, input logic [XLEN-1:0] rf);
        if (wb_RegWEn && wb_rd_add != 0 && wb_rd_add == a) return wb_dataW;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pc = 0; m_imm = 0; m_op1 = 0; m_op2 = 0;
        m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_ctrl = 0; m_scnt = 0; m_fcnt = 0;
    endtask

    task automatic check_outputs(input string pfx);
        chk({pfx, ".ex_valid"},  ex_valid,  m_valid);
        chk({pfx, ".ex_ctrl"},   ex_ctrl,   m_ctrl);
        chk({pfx, ".stall_cnt"}, stall_cnt, m_scnt);
        chk({pfx, ".flush_cnt"}, flush_cnt, m_fcnt);
        // Data fields are don't-care on a bubble; compare only live slots.
        if (m_valid) begin
            chk({pfx, ".ex_pc"},       ex_pc,       m_pc);
            chk({pfx, ".ex_imm"},      ex_imm,      m_imm);
            chk({pfx, ".ex_rs1_data"}, ex_rs1_data, m_op1);
            chk({pfx, ".ex_rs2_data"}, ex_rs2_data, m_op2);
            chk({pfx, ".ex_rs1_add"},  ex_rs1_add,  m_rs1a);
            chk({pfx, ".ex_rs2_add"},  ex_rs2_add,  m_rs2a);
            chk({pfx, ".ex_rd_add"},   ex_rd_add,   m_rd);
        end
    endtask

    task automatic check_all_zero(input string pfx);
        chk({pfx, ".stall_id"}, stall_id, 0);
        chk({pfx, ".ex_valid"}, ex_valid, 0);
        chk({pfx, ".ex_pc"}, ex_pc, 0);
        chk({pfx, ".ex_imm"}, ex_imm, 0);
        chk({pfx, ".ex_rs1_data"}, ex_rs1_data, 0);
        chk({pfx, ".ex_rs2_data"}, ex_rs2_data, 0);
        chk({pfx, ".ex_addrs"}, {ex_rs1_add, ex_rs2_add, ex_rd_add}, 0);
        chk({pfx, ".ex_ctrl"}, ex_ctrl, 0);
        chk({pfx, ".stall_cnt"}, stall_cnt, 0);
        chk({pfx, ".flush_cnt"}, flush_cnt, 0);
    endtask

    // Inputs have been driven just after a falling edge. Check stall_id,
    // advance one rising edge, update the model and compare the outputs.
    task automatic run_cycle(input string pfx);
        logic exp_lu, exp_stall;
        #1;
        exp_lu    = model_lu();
        exp_stall = (exp_lu || hold_ex) && !flush;
        last_stall = stall_id;
        chk({pfx, ".stall_id"}, stall_id, exp_stall);
        @(posedge clk);
        if (exp_stall && m_scnt < CNT_MAX) m_scnt++;
        if (flush && (id_valid || m_valid) && m_fcnt < CNT_MAX) m_fcnt++;
        if (flush) begin
            m_valid = 0; m_ctrl = 0;
        end else if (hold_ex) begin
            // slot frozen
        end else if (exp_lu) begin
            m_valid = 0; m_ctrl = 0;
        end else begin
            m_valid = id_valid;
            m_pc = id_pc; m_imm = id_imm;
            m_op1 = fwd(id_rs1_add, rs1);
            m_op2 = fwd(id_rs2_add, rs2);
            m_rs1a = id_rs1_add; m_rs2a = id_rs2_add; m_rd = id_rd_add;
            m_ctrl = id_valid ? id_ctrl : '0;
        end
        #1;
        check_outputs(pfx);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_pc = 0; id_rs1_add = 0; id_rs2_add = 0; id_rd_add = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_imm = 0; id_ctrl = 0;
        rs1 = 0; rs2 = 0; wb_RegWEn = 0; wb_rd_add = 0; wb_dataW = 0;
        ex_mem_read = 0; flush = 0; hold_ex = 0;
    endtask

    task automatic issue(input logic [XLEN-1:0] pc, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] rd, input logic u1, input logic u2);
        id_valid = 1; id_pc = pc; id_rs1_add = a1; id_rs2_add = a2; id_rd_add = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_imm = pc ^ 32'h55; id_ctrl = pc[15:0] | 16'h1;
        rs1 = pc + 1; rs2 = pc + 2;
    endtask

    task automatic randomize_inputs();
        id_valid    = ($urandom_range(0, 3) != 0);
        id_pc       = $urandom;
        id_rs1_add  = 5'($urandom_range(0, 7));
        id_rs2_add  = 5'($urandom_range(0, 7));
        id_rd_add   = 5'($urandom_range(0, 7));
        id_use_rs1  = 1'($urandom);
        id_use_rs2  = 1'($urandom);
        id_imm      = $urandom;
        id_ctrl     = 16'($urandom);
        rs1         = $urandom;
        rs2         = $urandom;
        wb_RegWEn   = 1'($urandom);
        wb_rd_add   = 5'($urandom_range(0, 7));
        wb_dataW    = $urandom;
        ex_mem_read = 1'($urandom);
        flush       = ($urandom_range(0, 7) == 0);
        hold_ex     = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        int s0, f0;
        logic [XLEN-1:0] held_pc;
        n_vec = 0; n_err = 0;
        idle_inputs();
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1;

        // Plain ALU op
        issue(32'h100, 5'd1, 5'd2, 5'd3, 1, 1);
        rs1 = 5; rs2 = 7; id_imm = 32'h10;
        run_cycle("alu");
        chk("alu.pc", ex_pc, 32'h100);
        chk("alu.rs1", ex_rs1_data, 5);
        chk("alu.rs2", ex_rs2_data, 7);
        chk("alu.rd", ex_rd_add, 3);
        chk("alu.stall", last_stall, 0);

        // Load-use on rs2 with rd=6: exactly one bubble
        issue(32'h200, 5'd1, 5'd2, 5'd6, 1, 0);
        run_cycle("lu.load");
        issue(32'h204, 5'd4, 5'd6, 5'd7, 1, 1);
        ex_mem_read = 1;
        run_cycle("lu.stall");
        chk("lu.stall_seen", last_stall, 1);
        chk("lu.bubble_valid", ex_valid, 0);
        chk("lu.bubble_ctrl", ex_ctrl, 0);
        chk("lu.stall_cnt", stall_cnt, 1);
        ex_mem_read = 0;
        run_cycle("lu.issue");
        chk("lu.nostall", last_stall, 0);
        chk("lu.issued_pc", ex_pc, 32'h204);

        // Same with rd=0: no stall
        issue(32'h300, 5'd1, 5'd2, 5'd0, 1, 0);
        run_cycle("lu0.load");
        issue(32'h304, 5'd0, 5'd0, 5'd7, 1, 1);
        ex_mem_read = 1;
        run_cycle("lu0.next");
        chk("lu0.nostall", last_stall, 0);
        chk("lu0.valid", ex_valid, 1);
        ex_mem_read = 0;

        // Writeback bypass
        issue(32'h400, 5'd9, 5'd2, 5'd5, 1, 1);
        rs1 = 32'h1; wb_RegWEn = 1; wb_rd_add = 9; wb_dataW = 32'hDEADBEEF;
        run_cycle("byp");
        chk("byp.rs1", ex_rs1_data, 32'hDEADBEEF);
        issue(32'h404, 5'd0, 5'd2, 5'd5, 1, 1);
        rs1 = 32'h1; wb_rd_add = 0;
        run_cycle("byp0");
        chk("byp0.rs1", ex_rs1_data, 32'h1);
        wb_RegWEn = 0;

        // Flush with load-use and hold simultaneously
        issue(32'h500, 5'd1, 5'd2, 5'd4, 0, 0);
        run_cycle("fl.load");
        s0 = m_scnt; f0 = m_fcnt;
        issue(32'h504, 5'd4, 5'd4, 5'd8, 1, 1);
        ex_mem_read = 1; hold_ex = 1; flush = 1;
        run_cycle("fl.kill");
        chk("fl.stall", last_stall, 0);
        chk("fl.valid", ex_valid, 0);
        chk("fl.fcnt", flush_cnt, f0 + 1);
        chk("fl.scnt", stall_cnt, s0);
        ex_mem_read = 0; hold_ex = 0; flush = 0;

        // Hold for three cycles with changing ID inputs
        issue(32'h600, 5'd1, 5'd2, 5'd3, 1, 1);
        run_cycle("hold.load");
        held_pc = ex_pc;
        s0 = m_scnt;
        for (int i = 0; i < 3; i++) begin
            issue(32'h700 + 32'(i * 4), 5'd1, 5'd2, 5'd3, 1, 1);
            hold_ex = 1;
            run_cycle("hold");
            chk("hold.stall", last_stall, 1);
            chk("hold.pc", ex_pc, 32'h600);
        end
        chk("hold.scnt", stall_cnt, s0 + 3);
        hold_ex = 0;

        // Drive stall_cnt to saturation, then stall once more
        hold_ex = 1;
        for (int i = 0; i < CNT_MAX + 2 && m_scnt < CNT_MAX; i++) run_cycle("sat.fill");
        chk("sat.full", stall_cnt, CNT_MAX);
        run_cycle("sat.more");
        chk("sat.stay", stall_cnt, CNT_MAX);

        // Reset asserted mid-stall, between clock edges
        #1;
        chk("rst.pre_stall", stall_id, 1);
        #2;
        rst_n = 0;
        #1;
        check_all_zero("rst.async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1;
        run_cycle("rst.after");
        chk("rst.nostall", last_stall, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            run_cycle("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
